// File: rtl/fp_operand_loader.sv
// Collects NUM_OPS packed floating-point words from a word-serial bus after a rising
// edge of enable, unpacks each into sign/exponent/significand and classifies it.
module fp_operand_loader #(
   parameter int EXP_W   = 5,
   parameter int MANT_W  = 10,
   parameter int NUM_OPS = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          enable,
   input  logic [EXP_W+MANT_W:0]         data_in,
   input  logic                          data_stb,
   output logic [NUM_OPS-1:0]            sign,
   output logic [NUM_OPS*EXP_W-1:0]      exp,
   output logic [NUM_OPS*(MANT_W+1)-1:0] mant,
   output logic [NUM_OPS-1:0]            is_zero,
   output logic [NUM_OPS-1:0]            is_sub,
   output logic [NUM_OPS-1:0]            is_inf,
   output logic [NUM_OPS-1:0]            is_nan,
   output logic                          busy,
   output logic                          valid,
   output logic                          aborted
);

   localparam int W     = 1 + EXP_W + MANT_W;
   localparam int MW    = MANT_W + 1;
   localparam int IDX_W = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OPS - 1);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_COLLECT = 2'd1;
   localparam logic [1:0] ST_DONE    = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             prev_enable_q, prev_enable_d;
   logic             armed_q, armed_d;
   logic             valid_q, valid_d;
   logic             aborted_q, aborted_d;

   logic [NUM_OPS-1:0]       sign_q, sign_d;
   logic [NUM_OPS*EXP_W-1:0] exp_q, exp_d;
   logic [NUM_OPS*MW-1:0]    mant_q, mant_d;
   logic [NUM_OPS-1:0]       zero_q, zero_d;
   logic [NUM_OPS-1:0]       sub_q, sub_d;
   logic [NUM_OPS-1:0]       inf_q, inf_d;
   logic [NUM_OPS-1:0]       nan_q, nan_d;

   logic             edge_det;
   logic             cap;
   logic [IDX_W-1:0] cap_idx;

   logic              in_sign;
   logic [EXP_W-1:0]  in_exp;
   logic [MANT_W-1:0] in_frac;
   logic              exp_zero;
   logic              exp_ones;
   logic              frac_zero;

   assign in_sign   = data_in[W-1];
   assign in_exp    = data_in[MANT_W +: EXP_W];
   assign in_frac   = data_in[MANT_W-1:0];
   assign exp_zero  = (in_exp == '0);
   assign exp_ones  = &in_exp;
   assign frac_zero = (in_frac == '0);

   // armed_q blocks an edge on the first cycle after reset so prev_enable samples first
   assign edge_det      = enable & ~prev_enable_q & armed_q;
   assign prev_enable_d = enable;
   assign armed_d       = 1'b1;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      valid_d   = 1'b0;
      aborted_d = 1'b0;
      cap       = 1'b0;
      cap_idx   = idx_q;
      case (state_q)
         ST_IDLE: begin
            if (edge_det) begin
               state_d = ST_COLLECT;
               idx_d   = '0;
               cap_idx = '0;
               cap     = data_stb;
            end
         end
         ST_COLLECT: begin
            if (!enable) begin
               state_d   = ST_IDLE;
               aborted_d = 1'b1;
            end else begin
               cap = data_stb;
            end
         end
         ST_DONE: begin
            if (!enable) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (cap) begin
         if (cap_idx == LAST_IDX) begin
            state_d = ST_DONE;
            valid_d = 1'b1;
         end else begin
            idx_d = cap_idx + IDX_W'(1);
         end
      end
   end

   // Only the addressed slot changes; every other slot keeps its last captured word
   always_comb begin
      sign_d = sign_q;
      exp_d  = exp_q;
      mant_d = mant_q;
      zero_d = zero_q;
      sub_d  = sub_q;
      inf_d  = inf_q;
      nan_d  = nan_q;
      for (int i = 0; i < NUM_OPS; i++) begin
         if (cap && (cap_idx == IDX_W'(i))) begin
            sign_d[i]                = in_sign;
            exp_d[i*EXP_W +: EXP_W]  = in_exp;
            mant_d[i*MW +: MW]       = {~exp_zero, in_frac};
            zero_d[i]                = exp_zero & frac_zero;
            sub_d[i]                 = exp_zero & ~frac_zero;
            inf_d[i]                 = exp_ones & frac_zero;
            nan_d[i]                 = exp_ones & ~frac_zero;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         idx_q         <= '0;
         prev_enable_q <= 1'b0;
         armed_q       <= 1'b0;
         valid_q       <= 1'b0;
         aborted_q     <= 1'b0;
         sign_q        <= '0;
         exp_q         <= '0;
         mant_q        <= '0;
         zero_q        <= '0;
         sub_q         <= '0;
         inf_q         <= '0;
         nan_q         <= '0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         prev_enable_q <= prev_enable_d;
         armed_q       <= armed_d;
         valid_q       <= valid_d;
         aborted_q     <= aborted_d;
         sign_q        <= sign_d;
         exp_q         <= exp_d;
         mant_q        <= mant_d;
         zero_q        <= zero_d;
         sub_q         <= sub_d;
         inf_q         <= inf_d;
         nan_q         <= nan_d;
      end
   end

   assign sign    = sign_q;
   assign exp     = exp_q;
   assign mant    = mant_q;
   assign is_zero = zero_q;
   assign is_sub  = sub_q;
   assign is_inf  = inf_q;
   assign is_nan  = nan_q;
   assign busy    = (state_q == ST_COLLECT);
   assign valid   = valid_q;
   assign aborted = aborted_q;

endmodule

// File: doc/fp_operand_loader.md
# fp_operand_loader

Parametrised successor to the single-word half-precision loader. It collects NUM_OPS packed IEEE-style floating-point words from a word-serial bus after a rising edge of `enable`. Each word is unpacked into sign, biased exponent and significand with the hidden bit restored, and classified as zero, subnormal, infinity or NaN. One `valid` pulse is issued when the whole operand set is present. It sits between the operand source and the FP datapath, which consumes all operands on the `valid` pulse.

## Interface
- EXP_W, 5, exponent field width.
- MANT_W, 10, fraction field width; packed word width W = 1+EXP_W+MANT_W.
- NUM_OPS, 2, operands per load (≥1); slot i occupies bits [i*w +: w] of each flattened output.
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  load request; a load arms on its low→high transition.
- data_in  in  W  packed word {sign, exp, frac}.
- data_stb  in  1  data_in carries a word this cycle.
- sign  out  NUM_OPS  sign bit per slot.
- exp  out  NUM_OPS*EXP_W  raw biased exponent per slot.
- mant  out  NUM_OPS*(MANT_W+1)  {hidden, frac} per slot; hidden = (exp != 0).
- is_zero, is_sub, is_inf, is_nan  out  NUM_OPS each  classification per slot.
- busy  out  1  high while collecting.
- valid  out  1  one-cycle pulse: all NUM_OPS slots freshly loaded.
- aborted  out  1  one-cycle pulse: load cancelled by enable dropping mid-collection.

## Operation
- Registered `prev_enable` detects the rising edge: edge = enable & !prev_enable.
- States: IDLE, COLLECT, DONE.
- IDLE → COLLECT on edge; idx cleared to 0. The edge cycle is already a collection cycle: if data_stb is high in that cycle, the word goes to slot 0.
- COLLECT, enable high, data_stb high: capture data_in into slot idx and increment idx. If idx == NUM_OPS-1, go to DONE and assert valid on that edge.
- COLLECT, data_stb low: hold; no timeout.
- COLLECT, enable low: go to IDLE and pulse aborted. data_stb in that cycle is ignored. Slots already overwritten keep their new values; valid is not asserted.
- DONE: ignore data_stb. Stay in DONE while enable is high. Go to IDLE when enable is low. Re-arming needs at least one cycle of enable low.
- Classification per word (e = exp field, f = frac):
  - zero: e==0 & f==0
  - sub: e==0 & f!=0
  - inf: e==all-ones & f==0
  - nan: e==all-ones & f!=0
  - Exactly one flag or none is set per slot; none means normal.
- Sign passes through unchanged, including -0 and NaN.
- A slot is written only when captured; unwritten slots hold their previous values.
- NUM_OPS=1 with data_stb tied high behaves as the legacy single-word loader: capture on the edge cycle, valid the next cycle.

## Timing
- Reset (async assert, sync-safe release): state IDLE, prev_enable 0, idx 0. All outputs 0: sign, exp, mant, flags, busy, valid, aborted.
- Capture latency: a word presented in cycle t appears on its slot outputs in cycle t+1.
- valid is high in the cycle after the last word's strobe cycle, for exactly one cycle. All slot outputs are stable while valid is high and until the next load captures.
- Minimum load time is NUM_OPS cycles (strobe every cycle, starting with the edge cycle).
- busy is high from the cycle after the edge until the cycle after the last capture (exclusive). In that cycle valid=1 and busy=0.
- aborted is high in the cycle after enable is sampled low in COLLECT.
- If enable falls in the same cycle the last word is strobed, the word is dropped, abort wins, and there is no valid.
- Edge in the same cycle as reset release: ignored; prev_enable re-samples first. Reset mid-collection discards the load with no valid and no aborted.

## Test plan
- Defaults, enable rises with data_stb=1: data_in 0x3C00 then 0xC000. Expect valid one cycle after the second word. Slot0: sign 0, exp 15, mant 0x400, no flags. Slot1: sign 1, exp 16, mant 0x400.
- Classification sweep: load pairs (0x8000, 0x0001) and (0x7C00, 0x7E00). Expect slot0 is_zero with sign 1; slot1 is_sub with mant 0x001; then is_inf with mant 0x400 and is_nan with mant 0x600.
- Gapped strobes: edge with data_stb=0, then 3 idle cycles, then two strobes. Expect busy high throughout, valid exactly once, and the correct words.
- Abort: edge, one word 0x4000, then enable low. Expect aborted pulse, no valid, slot0 = exp 16. A new edge then reloads both slots.
- Enable held high 10 cycles past DONE with data_stb toggling: no further captures and no second valid. Enable low for 1 cycle then high again gives a fresh load.
- Reset asserted mid-collection: all outputs 0 immediately (async) and no valid. Also run NUM_OPS=1 with EXP_W=8 and MANT_W=23: word 0x3F800000 gives exp 127, mant 0x800000, valid 1 cycle after the edge.
